// File: rtl/mesh_xy_router.sv
// Five-port mesh router: per-input FIFOs, dimension-ordered route decode on each
// FIFO head, per-output round-robin arbitration into registered output stages.
module mesh_xy_router #(
  parameter int DATA_W     = 32,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int ROUTE_YX   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_W-1:0]    my_x,
  input  logic [COORD_W-1:0]    my_y,
  input  logic [4:0]            in_valid,
  output logic [4:0]            in_ready,
  input  logic [5*DATA_W-1:0]   in_data,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready,
  output logic [5*DATA_W-1:0]   out_data
);

  // Handshake: a flit moves across any port on a rising edge where valid and
  // ready are both high; a source holds valid and data stable until that edge.
  localparam int NP    = 5;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [2:0] port_t;
  localparam port_t P_L = 3'd0;
  localparam port_t P_E = 3'd1;
  localparam port_t P_W = 3'd2;
  localparam port_t P_N = 3'd3;
  localparam port_t P_S = 3'd4;

  function automatic port_t route_of(input logic [2*COORD_W-1:0] hdr,
                                     input logic [COORD_W-1:0]   mx,
                                     input logic [COORD_W-1:0]   my);
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    port_t xp;
    port_t yp;
    dx = hdr[COORD_W-1:0];
    dy = hdr[2*COORD_W-1:COORD_W];
    xp = (dx > mx) ? P_E : ((dx < mx) ? P_W : P_L);
    yp = (dy > my) ? P_N : ((dy < my) ? P_S : P_L);
    if (ROUTE_YX != 0) route_of = (yp != P_L) ? yp : xp;
    else               route_of = (xp != P_L) ? xp : yp;
  endfunction

  logic [DATA_W-1:0] mem    [NP][FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr [NP];
  logic [PTR_W-1:0]  wr_ptr [NP];
  logic [CNT_W-1:0]  count  [NP];
  logic [DATA_W-1:0] head   [NP];
  port_t             route  [NP];
  logic [NP-1:0]     push;
  logic [NP-1:0]     pop;

  logic [NP-1:0]     req    [NP];
  logic [NP-1:0]     grant  [NP];
  port_t             winner [NP];
  port_t             rr_ptr [NP];
  logic [NP-1:0]     free_o;

  always_comb begin
    for (int p = 0; p < NP; p++) begin
      in_ready[p] = (count[p] < CNT_W'(FIFO_DEPTH));
      push[p]     = in_valid[p] & in_ready[p];
      head[p]     = mem[p][rd_ptr[p]];
      route[p]    = route_of(head[p][2*COORD_W-1:0], my_x, my_y);
    end
  end

  // Round-robin search starts at rr_ptr[o] and wraps from port 4 back to port 0.
  always_comb begin
    logic found;
    int   c;
    found = 1'b0;
    c     = 0;
    pop   = '0;
    for (int o = 0; o < NP; o++) begin
      free_o[o] = ~out_valid[o] | out_ready[o];
      grant[o]  = '0;
      winner[o] = P_L;
      found     = 1'b0;
      for (int p = 0; p < NP; p++) begin
        req[o][p] = (count[p] != '0) && (route[p] == port_t'(o));
      end
      for (int k = 0; k < NP; k++) begin
        c = int'(rr_ptr[o]) + k;
        if (c >= NP) c = c - NP;
        if (!found && free_o[o] && req[o][c]) begin
          found       = 1'b1;
          grant[o][c] = 1'b1;
          winner[o]   = port_t'(c);
        end
      end
    end
    for (int p = 0; p < NP; p++) begin
      for (int o = 0; o < NP; o++) begin
        pop[p] = pop[p] | grant[o][p];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NP; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (push[p]) wr_ptr[p] <= wr_ptr[p] + PTR_W'(1);
        if (pop[p])  rd_ptr[p] <= rd_ptr[p] + PTR_W'(1);
        count[p] <= count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
    end
  end

  // Storage needs no reset: the counts alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= in_data[p*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_data  <= '0;
      for (int o = 0; o < NP; o++) rr_ptr[o] <= P_L;
    end else begin
      for (int o = 0; o < NP; o++) begin
        if (grant[o] != '0) begin
          out_valid[o]                   <= 1'b1;
          out_data[o*DATA_W +: DATA_W]   <= head[winner[o]];
          rr_ptr[o]                      <= (winner[o] == P_S) ? P_L : winner[o] + 3'd1;
        end else if (out_ready[o]) begin
          out_valid[o] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mesh_xy_router.sv
// Bench for mesh_xy_router: directed route/contention/backpressure/reset cases and
// randomized traffic scored against a route model with per-source ordering.
module tb_mesh_xy_router;

  localparam int MY = 2;

  logic         clk;
  logic         rst_n;
  logic [3:0]   my_x = 4'd2;
  logic [3:0]   my_y = 4'd2;

  logic [4:0]   a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [159:0] a_in_data, a_out_data;
  logic [4:0]   b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [159:0] b_in_data, b_out_data;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] exp_q[$];
  logic [31:0] pend_q[$];
  logic [31:0] want_q[$];
  logic [31:0] out_log[$];
  int          out_cyc[$];
  int          out_port[$];
  logic [4:0]  mon_hold;
  logic [31:0] mon_last [5];

  mesh_xy_router #(.DATA_W(32), .COORD_W(4), .FIFO_DEPTH(2), .ROUTE_YX(0)) dut_xy (
    .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data)
  );

  mesh_xy_router #(.DATA_W(32), .COORD_W(4), .FIFO_DEPTH(2), .ROUTE_YX(1)) dut_yx (
    .clk(clk), .rst_n(rst_n), .my_x(my_x), .my_y(my_y),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mk(input int src, input int seq, input int dx, input int dy);
    logic [31:0] f;
    f = 32'(seq) << 11;
    f[10:8] = 3'(src);
    f[7:4]  = 4'(dy);
    f[3:0]  = 4'(dx);
    return f;
  endfunction

  // Output port as a function of signed distance to the destination.
  function automatic int model_route(input logic [31:0] f, input bit yx);
    int dx, dy, xp, yp;
    dx = int'(f[3:0]) - MY;
    dy = int'(f[7:4]) - MY;
    xp = (dx > 0) ? 1 : ((dx < 0) ? 2 : 0);
    yp = (dy > 0) ? 3 : ((dy < 0) ? 4 : 0);
    if (yx) return (yp != 0) ? yp : xp;
    return (xp != 0) ? xp : yp;
  endfunction

  // ---------------- scoreboard (XY instance) ----------------
  initial begin
    logic [31:0] d, e;
    int hit;
    mon_hold = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        mon_hold = '0;
      end else begin
        for (int o = 0; o < 5; o++) begin
          d = a_out_data[o*32 +: 32];
          if (mon_hold[o]) begin
            check("hold_valid", 32'(a_out_valid[o]), 32'd1);
            check("hold_data", d, mon_last[o]);
          end
          if (a_out_valid[o]) begin
            check("route", 32'(model_route(d, 1'b0)), 32'(o));
            if (a_out_ready[o]) begin
              hit = -1;
              for (int i = 0; i < exp_q.size(); i++) begin
                e = exp_q[i];
                if (hit < 0 && e[10:8] == d[10:8] && model_route(e, 1'b0) == o) hit = i;
              end
              check("sb_found", 32'(hit >= 0), 32'd1);
              if (hit >= 0) begin
                check("sb_order", d, exp_q[hit]);
                exp_q.delete(hit);
              end
              out_log.push_back(d);
              out_cyc.push_back(cyc);
              out_port.push_back(o);
            end
          end
          mon_hold[o] = a_out_valid[o] & ~a_out_ready[o];
          mon_last[o] = d;
        end
        for (int p = 0; p < 5; p++) begin
          if (a_in_valid[p] && a_in_ready[p]) exp_q.push_back(a_in_data[p*32 +: 32]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_log();
    out_log.delete();
    out_cyc.delete();
    out_port.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_in_valid = '0; a_in_data = '0; a_out_ready = '1;
    b_in_valid = '0; b_in_data = '0; b_out_ready = '1;
    pend_q.delete();
    #1;
    check("rst_in_ready", 32'(a_in_ready), 32'h1f);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data", 32'(|a_out_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_log();
  endtask

  // One clock of the XY instance: each port offers its oldest pending flit.
  task automatic tick();
    logic [4:0]  v;
    logic [31:0] t;
    v = '0;
    a_in_data = '0;
    for (int p = 0; p < 5; p++) begin
      for (int i = 0; i < pend_q.size(); i++) begin
        t = pend_q[i];
        if (!v[p] && t[10:8] == 3'(p)) begin
          v[p] = 1'b1;
          a_in_data[p*32 +: 32] = t;
        end
      end
    end
    a_in_valid = v;
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      if (a_in_valid[p] && a_in_ready[p]) begin
        for (int i = 0; i < pend_q.size(); i++) begin
          if (pend_q[i] == a_in_data[p*32 +: 32]) begin
            pend_q.delete(i);
            break;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic pending_on(input int p, output int n);
    logic [31:0] t;
    n = 0;
    for (int i = 0; i < pend_q.size(); i++) begin
      t = pend_q[i];
      if (t[10:8] == 3'(p)) n++;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dxs [5] = '{3, 1, 2, 2, 2};
    int dys [5] = '{0, 5, 7, 0, 2};
    int eo  [5] = '{1, 2, 3, 4, 0};
    int ydx [2] = '{3, 1};
    int ydy [2] = '{0, 5};
    int yeo [2] = '{4, 3};
    int par_src [5] = '{0, 1, 3, 4, 2};
    int par_dx  [5] = '{3, 1, 2, 2, 2};
    int par_dy  [5] = '{2, 2, 1, 3, 2};
    int par_out [5] = '{1, 2, 4, 3, 0};
    logic [31:0] f;
    int guard, n, seq;

    rst_n = 1'b1;
    a_in_valid = '0; a_in_data = '0; a_out_ready = '1;
    b_in_valid = '0; b_in_data = '0; b_out_ready = '1;
    #2;
    do_reset();

    // route decode, XY, single flits on the local port
    for (int i = 0; i < 5; i++) begin
      f = mk(0, i, dxs[i], dys[i]);
      a_in_valid = 5'b00001;
      a_in_data = '0;
      a_in_data[31:0] = f;
      @(posedge clk); #1;
      a_in_valid = '0;
      check("dec_lat0", 32'(a_out_valid), 32'd0);
      @(posedge clk); #1;
      check("dec_valid", 32'(a_out_valid), 32'd1 << eo[i]);
      check("dec_data", a_out_data[eo[i]*32 +: 32], f);
      @(posedge clk); #1;
      check("dec_drain", 32'(a_out_valid), 32'd0);
    end

    // route decode, YX instance
    for (int i = 0; i < 2; i++) begin
      f = mk(0, i, ydx[i], ydy[i]);
      b_in_valid = 5'b00001;
      b_in_data = '0;
      b_in_data[31:0] = f;
      @(posedge clk); #1;
      b_in_valid = '0;
      check("yx_lat0", 32'(b_out_valid), 32'd0);
      @(posedge clk); #1;
      check("yx_valid", 32'(b_out_valid), 32'd1 << yeo[i]);
      check("yx_data", b_out_data[yeo[i]*32 +: 32], f);
    end

    // contention: E, W, N each send 3 flits to the local output
    do_reset();
    want_q.delete();
    for (int k = 0; k < 3; k++) begin
      for (int p = 1; p <= 3; p++) begin
        pend_q.push_back(mk(p, k, 2, 2));
        want_q.push_back(mk(p, k, 2, 2));
      end
    end
    guard = 0;
    while ((pend_q.size() > 0 || out_log.size() < 9) && guard < 40) begin
      tick();
      guard++;
    end
    check("cont_timeout", 32'(guard < 40), 32'd1);
    check("cont_count", 32'(out_log.size()), 32'd9);
    for (int i = 0; i < out_log.size() && i < 9; i++) begin
      check("cont_data", out_log[i], want_q[i]);
      check("cont_port", 32'(out_port[i]), 32'd0);
      check("cont_gap", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
    end

    // backpressure on the east output
    do_reset();
    a_out_ready = 5'b11101;
    for (int k = 0; k < 4; k++) pend_q.push_back(mk(0, k, 5, 2));
    for (int i = 0; i < 6; i++) tick();
    check("bp_valid", 32'(a_out_valid[1]), 32'd1);
    check("bp_data", a_out_data[63:32], mk(0, 0, 5, 2));
    check("bp_in_ready", 32'(a_in_ready[0]), 32'd0);
    check("bp_pending", 32'(pend_q.size()), 32'd1);
    a_out_ready = '1;
    clear_log();
    guard = 0;
    while (out_log.size() < 4 && guard < 20) begin
      tick();
      guard++;
    end
    check("bp_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < out_log.size() && i < 4; i++) begin
      check("bp_order", out_log[i], mk(0, i, 5, 2));
      check("bp_gap", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
    end

    // five non-conflicting flows in the same cycle
    do_reset();
    for (int i = 0; i < 5; i++) pend_q.push_back(mk(par_src[i], 0, par_dx[i], par_dy[i]));
    tick();
    check("par_accept", 32'(pend_q.size()), 32'd0);
    check("par_lat0", 32'(a_out_valid), 32'd0);
    tick();
    check("par_valid", 32'(a_out_valid), 32'h1f);
    for (int i = 0; i < 5; i++)
      check("par_data", a_out_data[par_out[i]*32 +: 32], mk(par_src[i], 0, par_dx[i], par_dy[i]));

    // asynchronous reset with traffic in flight
    do_reset();
    a_out_ready = 5'b10111;
    pend_q.push_back(mk(0, 9, 2, 2));
    for (int k = 0; k < 3; k++) pend_q.push_back(mk(0, k, 2, 5));
    for (int i = 0; i < 5; i++) tick();
    check("mid_valid3", 32'(a_out_valid[3]), 32'd1);
    check("mid_data3", a_out_data[127:96], mk(0, 0, 2, 5));
    check("mid_full", 32'(a_in_ready[0]), 32'd0);
    #2;
    rst_n = 1'b0;
    a_in_valid = '0;
    pend_q.delete();
    #1;
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_ready", 32'(a_in_ready), 32'h1f);
    check("mid_rst_data", 32'(|a_out_data), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    a_out_ready = '1;
    clear_log();
    for (int p = 0; p < 5; p++) pend_q.push_back(mk(p, 1, 2, 2));
    guard = 0;
    while (out_log.size() < 5 && guard < 30) begin
      tick();
      guard++;
    end
    check("rr_count", 32'(out_log.size()), 32'd5);
    for (int i = 0; i < out_log.size() && i < 5; i++) begin
      check("rr_order", out_log[i], mk(i, 1, 2, 2));
      check("rr_gap", 32'(out_cyc[i] - out_cyc[0]), 32'(i));
    end

    // randomized traffic with random downstream stalls
    do_reset();
    seq = 100;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 5; p++) begin
        pending_on(p, n);
        if (n < 2 && $urandom_range(0, 2) == 0) begin
          pend_q.push_back(mk(p, seq, int'($urandom_range(0, 15)), int'($urandom_range(0, 15))));
          seq++;
        end
      end
      a_out_ready = 5'($urandom);
      tick();
    end
    a_out_ready = '1;
    guard = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && guard < 200) begin
      tick();
      guard++;
    end
    check("rand_pending", 32'(pend_q.size()), 32'd0);
    check("rand_drain", 32'(exp_q.size()), 32'd0);
    tick();
    check("rand_idle", 32'(a_out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mesh_xy_router.md
Name: mesh_xy_router

Overview:
- Sequential, parametrised successor to the combinational routing-decision logic.
- 5-port mesh router: Local, East, West, North, South.
- Per-input FIFO buffering, dimension-ordered (XY or YX) route computation, per-output round-robin arbitration, registered outputs with valid/ready handshakes.
- Sits at each mesh tile between the tile's local port and its four neighbours.

Parameters:
- DATA_W, 32, flit width in bits; must be ≥ 2*COORD_W.
- COORD_W, 4, width of each destination coordinate field.
- FIFO_DEPTH, 2, entries per input FIFO; power of two, ≥ 2.
- ROUTE_YX, 0, 0 = XY routing (X first); 1 = YX routing (Y first).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- my_x  in  COORD_W  this tile's X coordinate; static.
- my_y  in  COORD_W  this tile's Y coordinate; static.
- in_valid  in  5  per-input flit valid; bit p = port p (0 L, 1 E, 2 W, 3 N, 4 S).
- in_ready  out  5  per-input FIFO can accept.
- in_data  in  5*DATA_W  flattened; port p at [p*DATA_W +: DATA_W].
- out_valid  out  5  per-output flit valid.
- out_ready  in  5  per-output downstream accept.
- out_data  out  5*DATA_W  flattened, same packing as in_data.

Behaviour:
- Flit format: dst_x = data[COORD_W-1:0]; dst_y = data[2*COORD_W-1:COORD_W]. Single-flit packets. Payload passes through unmodified.
- Reset (async assert, sync deassert by the driver):
  - all FIFOs empty; in_ready = 5'b11111.
  - out_valid = 0, out_data = 0.
  - all round-robin pointers = 0.
- Input side:
  - in_ready[p] = (count[p] < FIFO_DEPTH), from registered count only; no same-cycle pop bypass.
  - Transfer occurs when in_valid[p] & in_ready[p] at the edge. in_valid asserted while in_ready=0 is ignored.
  - A simultaneous push and pop on a full FIFO is impossible, because in_ready is already 0.
- Route computation (combinational on each FIFO head), unsigned compares:
  - XY: dst_x > my_x → E; dst_x < my_x → W; else dst_y > my_y → N; dst_y < my_y → S; else L.
  - YX: Y comparison first, then X, using the same mapping.
- Arbitration, per output o, each cycle:
  - Requesters: non-empty inputs whose head routes to o.
  - Output register o is free if out_valid[o] = 0, or if out_valid[o] & out_ready[o] (drained this edge).
  - If free and there are requesters: grant the first requester found searching upward from rr_ptr[o], wrapping 4→0.
  - At the edge: load out_data[o] with the head, set out_valid[o] = 1, pop the winner's FIFO, set rr_ptr[o] = winner+1 mod 5.
  - If drained and no requester: out_valid[o] ← 0 and out_data holds its last value.
  - If out_valid[o] & ~out_ready[o]: out_valid and out_data stay stable and no grant is made.
- Each input requests exactly one output, so there are never two pops per FIFO per cycle.
- Latency: a flit accepted at edge k appears with out_valid at edge k+1 if uncontended. Throughput is 1 flit/cycle/output.
- Ordering: flits from the same input to the same output stay in order.
- A U-turn (route equal to arrival port) is legal and is forwarded normally.
- Reset mid-operation flushes all buffered and registered flits immediately.

Test Plan:
- Route decode, my=(2,2), XY, one flit each on port L: dst (3,0)→E; (1,5)→W; (2,7)→N; (2,0)→S; (2,2)→L. Each out_valid exactly 1 cycle after acceptance with payload intact. Repeat with ROUTE_YX=1: (3,0)→S, (1,5)→N.
- Contention: ports E, W, N each hold 3 flits to dst (2,2), out_ready[0]=1 continuously. Local output grant order is E,W,N,E,W,N,E,W,N, one per cycle, with no bubbles.
- Backpressure, FIFO_DEPTH=2: hold out_ready[1]=0 and inject 4 flits on L to (5,2). The first goes to the out register, the next 2 fill the FIFO, and in_ready[0] drops to 0 before the 4th. After out_ready[1]=1, all 4 emerge in order on consecutive cycles with out_data stable while stalled.
- Parallel non-conflicting: simultaneous flits L→E, E→W, N→S, S→N, W→L in one cycle. All five outputs valid on the next edge; nothing is stalled.
- Reset mid-operation: with 2 flits buffered and out_valid[3]=1, pulse rst_n low asynchronously (no clock edge). out_valid=0 and in_ready=5'b11111 immediately. After release, new traffic round-robins starting from port 0.
